// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM burst arbiter in front of the single SDRAM controller slave.
// Port 0 (video reader) may force priority with m0_urgent; read returns are routed by a tag FIFO.
//
// state   | meaning
// IDLE    | no grant; arbitrate between eligible ports
// CMD     | granted command presented to the slave
// WR_DATA | remaining beats of a locked write burst
module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic                m0_urgent,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [BURST_W-1:0]  m1_burstcount,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                protocol_err
);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, CMD, WR_DATA} state_t;

    state_t               state, state_nxt;
    logic                 grant, grant_nxt, last_grant, last_grant_nxt;
    logic [BURST_W-1:0]   beats_left, beats_left_nxt, lat_bc;
    logic [ADDR_W-1:0]    lat_addr;
    logic                 lat_en, push, pop;

    logic [BURST_W-1:0]   bc0, bc1, g_bc;
    logic                 g_read, g_write;
    logic [ADDR_W-1:0]    g_address;
    logic [DATA_W-1:0]    g_writedata;
    logic [DATA_W/8-1:0]  g_byteenable;
    logic                 elig0, elig1, fifo_full, fifo_empty;

    logic [BURST_W:0]     tag_mem [MAX_PENDING];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     tag_cnt;
    logic [BURST_W-1:0]   ret_beats, head_bc;
    logic                 head_port, ret_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A zero burstcount is a single beat everywhere downstream.
    assign bc0 = (m0_burstcount == '0) ? BURST_W'(1) : m0_burstcount;
    assign bc1 = (m1_burstcount == '0) ? BURST_W'(1) : m1_burstcount;

    assign g_read       = grant ? m1_read       : m0_read;
    assign g_write      = grant ? m1_write      : m0_write;
    assign g_address    = grant ? m1_address    : m0_address;
    assign g_writedata  = grant ? m1_writedata  : m0_writedata;
    assign g_byteenable = grant ? m1_byteenable : m0_byteenable;
    assign g_bc         = grant ? bc1           : bc0;

    assign fifo_empty = (tag_cnt == '0);
    assign fifo_full  = (tag_cnt == CNT_W'(MAX_PENDING));
    assign elig0      = m0_write || (m0_read && !fifo_full);
    assign elig1      = m1_write || (m1_read && !fifo_full);

    assign {head_port, head_bc} = tag_mem[rd_ptr];
    assign ret_ok           = s_readdatavalid && !fifo_empty;
    assign pop              = ret_ok && (ret_beats == head_bc - BURST_W'(1));
    assign m0_readdatavalid = ret_ok && !head_port;
    assign m1_readdatavalid = ret_ok && head_port;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beats_left_nxt = beats_left;
        lat_en         = 1'b0;
        push           = 1'b0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = g_address;
        s_burstcount   = g_bc;
        s_writedata    = g_writedata;
        s_byteenable   = g_byteenable;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    if (elig0 && elig1) grant_nxt = m0_urgent ? 1'b0 : !last_grant;
                    else                grant_nxt = elig1;
                    last_grant_nxt = grant_nxt;
                    state_nxt      = CMD;
                end
            end
            CMD: begin
                s_read  = g_read;
                s_write = g_write;
                if (grant) m1_waitrequest = s_waitrequest;
                else       m0_waitrequest = s_waitrequest;
                if (!g_read && !g_write) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    if (g_write) begin
                        beats_left_nxt = g_bc - BURST_W'(1);
                        lat_en         = 1'b1;
                        state_nxt      = (g_bc == BURST_W'(1)) ? IDLE : WR_DATA;
                    end else begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WR_DATA: begin
                s_write      = g_write;
                s_address    = lat_addr;
                s_burstcount = lat_bc;
                if (grant) m1_waitrequest = s_waitrequest;
                else       m0_waitrequest = s_waitrequest;
                if (g_write && !s_waitrequest) begin
                    beats_left_nxt = beats_left - BURST_W'(1);
                    if (beats_left == BURST_W'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            beats_left   <= '0;
            lat_addr     <= '0;
            lat_bc       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tag_cnt      <= '0;
            ret_beats    <= '0;
            protocol_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beats_left <= beats_left_nxt;
            if (lat_en) begin
                lat_addr <= g_address;
                lat_bc   <= g_bc;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                ret_beats <= '0;
            end else if (ret_ok) begin
                ret_beats <= ret_beats + BURST_W'(1);
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (s_readdatavalid && fifo_empty) protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= {grant, g_bc};
    end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port Avalon-MM burst arbiter that shares the single SDRAM controller slave between the video frame reader (port 0, feeding the clocked-video output path) and the PCIe frame writer (port 1, DMA of frames from the host). It sits between the two masters and the SDRAM controller's Avalon-MM slave in the `altpll_sdram_clk` domain. It holds each grant for a complete burst and routes read responses back to their owners. Port 0 gets urgent priority so the video output never underflows.

## Interface

Parameters:
- `ADDR_W`, 25: word address width.
- `DATA_W`, 32: data width; matches the 32-bit SDRAM bus.
- `BURST_W`, 4: burstcount width; maximum burst is 2^(BURST_W-1) = 8.
- `MAX_PENDING`, 4: depth of the outstanding-read tag FIFO.

Ports (x = 0 or 1 for the two master-facing ports):
- `clk`, in, 1: SDRAM-domain clock. It is the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `mx_address`, in, ADDR_W: burst start address.
- `mx_read`, in, 1: read request.
- `mx_write`, in, 1: write request/beat.
- `mx_writedata`, in, DATA_W: write data.
- `mx_byteenable`, in, DATA_W/8: byte enables.
- `mx_burstcount`, in, BURST_W: burst length; 0 is treated as 1.
- `mx_waitrequest`, out, 1: Avalon waitrequest to master x.
- `mx_readdata`, out, DATA_W: read data (`s_readdata` broadcast to both ports).
- `mx_readdatavalid`, out, 1: read beat valid for master x.
- `m0_urgent`, in, 1: video FIFO below low-water mark.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`, `s_burstcount`, out: command to the SDRAM controller. Widths are as above.
- `s_waitrequest`, in, 1: SDRAM controller stall.
- `s_readdata`, in, DATA_W: read data from the controller.
- `s_readdatavalid`, in, 1: read beat valid from the controller.
- `protocol_err`, out, 1: sticky; set by an unexpected `s_readdatavalid`.

## Operation

- FSM states:
  - IDLE: no grant.
  - CMD: the granted command is presented to the slave.
  - WR_DATA: remaining write beats of a locked burst.
- Eligibility: port x is eligible when `mx_read` or `mx_write` is high.
  - A read is ineligible while the pending FIFO holds MAX_PENDING entries.
- Arbitration, evaluated in IDLE:
  - One eligible port: it wins.
  - Both eligible and `m0_urgent` high: port 0 wins.
  - Both eligible otherwise: the port that is not `last_grant` wins.
  - The grant register and `last_grant` update; the FSM moves to CMD.
- In CMD and WR_DATA:
  - `s_*` command outputs are driven combinationally from the granted port.
  - The granted port's waitrequest equals `s_waitrequest`.
  - The non-granted port sees waitrequest = 1.
- In IDLE: `s_read` = `s_write` = 0 and both waitrequests = 1.
- CMD, read accepted (`s_waitrequest` = 0): push {port, burstcount} into the tag FIFO, then go to IDLE.
- CMD, write beat accepted:
  - `beats_left` = burstcount − 1.
  - If `beats_left` is 0, go to IDLE; otherwise go to WR_DATA.
- WR_DATA:
  - Each accepted beat decrements `beats_left`.
  - When the last beat is accepted, go to IDLE.
  - `s_burstcount` and `s_address` hold the values latched in CMD.
- Read return:
  - `mx_readdatavalid` = `s_readdatavalid` AND (FIFO head port == x).
  - A beat counter counts returned beats; at head burstcount the entry is popped and the counter is cleared.
  - A push and a pop in the same cycle are both applied.
- `s_readdatavalid` while the FIFO is empty: the beat is dropped and `protocol_err` is set. Only reset clears it.

## Timing

- Reset values:
  - FSM IDLE, FIFO empty, `beats_left` 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `s_read` = `s_write` = 0.
  - Both waitrequests = 1, both readdatavalids = 0, `protocol_err` = 0.
- Grant latency: a request seen in IDLE at cycle N reaches the `s_*` outputs at cycle N+1. Minimum turnaround between commands is 2 cycles (CMD → IDLE → CMD).
- Read return path is combinational, 0 cycles from `s_readdatavalid` to `mx_readdatavalid`.
- A write burst is never interleaved or preempted, even if `m0_urgent` rises mid-burst.
- Reads from both ports may be outstanding simultaneously. Returns are in issue order.
- Reset mid-burst abandons all state. Masters and the SDRAM controller must be reset in the same cycle.

## Test plan

1. Port 1 writes a burst of 4 at 0x100 with `s_waitrequest` = 0. Expect `s_write` high for 4 consecutive cycles starting 1 cycle after the request, `s_burstcount` = 4, and `m0_waitrequest` = 1 throughout.
2. Both ports issue reads each cycle, `m0_urgent` = 0. Expect grants alternating 0,1,0,1. With `m0_urgent` = 1, expect every grant to go to port 0.
3. Port 0 reads a burst of 8, then port 1 reads a burst of 2. The slave returns 10 beats. Expect `m0_readdatavalid` on beats 1–8, `m1_readdatavalid` on beats 9–10, and the FIFO empty afterwards.
4. Issue 4 reads with no returns (MAX_PENDING = 4). Expect a 5th read to see waitrequest = 1 with no `s_read`. After the first return completes, expect the 5th read to be issued.
5. `m0_urgent` rises during port 1 write beat 2 of 8. Expect all 8 beats to complete before port 0 is granted.
6. Pulse `s_readdatavalid` after reset with no reads issued. Expect `protocol_err` = 1 and to stay 1 until `reset`, with no `mx_readdatavalid` asserted.
